// File: rtl/bcd_chain_counter.sv
// bcd_chain_counter: DIGITS cascaded modulo-MODULUS digits, up/down, clear, clamped load.
// Optional macro BCD_CHAIN_ONESHOT_EN: stop at terminal count and raise done.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   en, up_dn      count enable, direction (1 = up)
//   clr, load, din synchronous clear, parallel load of din (digit i = din[i*DW +: DW])
//   cnt            current count, same packing as din
//   tc, cout       terminal count (combinational), cascade carry/borrow
//   load_err       one-cycle pulse after a load that clamped a digit
//   done           one-shot completion flag (tied 0 without the macro)
module bcd_chain_counter #(
    parameter int MODULUS = 10,
    parameter int DIGITS  = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             en,
    input  logic                             up_dn,
    input  logic                             clr,
    input  logic                             load,
    input  logic [DIGITS*$clog2(MODULUS)-1:0] din,
    output logic [DIGITS*$clog2(MODULUS)-1:0] cnt,
    output logic                             tc,
    output logic                             cout,
    output logic                             load_err,
    output logic                             done
);

    localparam int DW = $clog2(MODULUS);
    localparam int W  = DIGITS * DW;
    localparam logic [DW-1:0] DMAX = DW'(MODULUS - 1);
    localparam logic [DW:0]   DLIM = (DW+1)'(MODULUS);

    logic [W-1:0]    cnt_q;
    logic [W-1:0]    cnt_nxt;
    logic [W-1:0]    din_clamp;
    logic [DIGITS:0] lo_max;
    logic [DIGITS:0] lo_zero;
    logic            clamp_any;
    logic            err_q;
    logic            step;

    // lo_max[i] / lo_zero[i]: every digit below i is at MODULUS-1 / 0,
    // so digit i is the one that carries or borrows this step.
    always_comb begin
        lo_max     = '0;
        lo_zero    = '0;
        lo_max[0]  = 1'b1;
        lo_zero[0] = 1'b1;
        cnt_nxt    = cnt_q;
        din_clamp  = '0;
        clamp_any  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            lo_max[i+1]  = lo_max[i] & (cnt_q[i*DW +: DW] == DMAX);
            lo_zero[i+1] = lo_zero[i] & (cnt_q[i*DW +: DW] == '0);
            if (up_dn && lo_max[i]) begin
                if (cnt_q[i*DW +: DW] == DMAX)
                    cnt_nxt[i*DW +: DW] = '0;
                else
                    cnt_nxt[i*DW +: DW] = cnt_q[i*DW +: DW] + DW'(1);
            end else if (!up_dn && lo_zero[i]) begin
                if (cnt_q[i*DW +: DW] == '0)
                    cnt_nxt[i*DW +: DW] = DMAX;
                else
                    cnt_nxt[i*DW +: DW] = cnt_q[i*DW +: DW] - DW'(1);
            end
            if ({1'b0, din[i*DW +: DW]} >= DLIM) begin
                din_clamp[i*DW +: DW] = DMAX;
                clamp_any             = 1'b1;
            end else begin
                din_clamp[i*DW +: DW] = din[i*DW +: DW];
            end
        end
    end

    assign tc       = up_dn ? lo_max[DIGITS] : lo_zero[DIGITS];
    assign cnt      = cnt_q;
    assign load_err = err_q;

`ifdef BCD_CHAIN_ONESHOT_EN
    logic done_q;

    // Once done, the counter is frozen until clr, load or reset.
    assign step = en & ~done_q;
    assign cout = step & tc;
    assign done = done_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (load) begin
            cnt_q  <= din_clamp;
            err_q  <= clamp_any;
            done_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (step) begin
                if (tc)
                    done_q <= 1'b1;
                else
                    cnt_q <= cnt_nxt;
            end
        end
    end
`else
    assign step = en;
    assign cout = en & tc;
    assign done = 1'b0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (load) begin
            cnt_q <= din_clamp;
            err_q <= clamp_any;
        end else begin
            err_q <= 1'b0;
            if (step)
                cnt_q <= cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_chain_counter.sv
// tb_bcd_chain_counter: scoreboard bench for bcd_chain_counter, MODULUS=10, DIGITS=2.
// Follows BCD_CHAIN_ONESHOT_EN the same way the design does.
module tb_bcd_chain_counter;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] cnt;
    logic       tc;
    logic       cout;
    logic       load_err;
    logic       done;

    bcd_chain_counter #(.MODULUS(10), .DIGITS(2)) dut (
        .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .din(din), .cnt(cnt), .tc(tc), .cout(cout),
        .load_err(load_err), .done(done)
    );

    always #5 clk = ~clk;

`ifdef BCD_CHAIN_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] cnt;
        logic       err;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   npass = 0;
    int   ntotal = 0;

    // Reference model: the count as an integer 0..99.
    int m_v = 0;
    bit m_err = 0;
    bit m_done = 0;

    function automatic logic [7:0] pack(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic bit m_tc(input bit up);
        return up ? (m_v == 99) : (m_v == 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntotal++;
        if (got === exp)
            npass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_edge();
        int d1, d0;
        if (clr) begin
            m_v = 0; m_err = 0; m_done = 0;
        end else if (load) begin
            d1 = int'(din[7:4]);
            d0 = int'(din[3:0]);
            m_err = (d1 > 9) || (d0 > 9);
            if (d1 > 9) d1 = 9;
            if (d0 > 9) d0 = 9;
            m_v = d1 * 10 + d0;
            m_done = 0;
        end else begin
            m_err = 0;
            if (en && !m_done) begin
                if (ONESHOT && m_tc(up_dn))
                    m_done = 1;
                else if (up_dn)
                    m_v = (m_v + 1) % 100;
                else
                    m_v = (m_v + 99) % 100;
            end
        end
    endtask

    task automatic check_comb(input string tag);
        bit t;
        t = m_tc(up_dn);
        check({tag, ".tc"}, 32'(tc), 32'(t));
        check({tag, ".cout"}, 32'(cout), 32'(en & t & ~m_done));
    endtask

    // Drive inputs, push the expected post-edge state, clock, pop and compare.
    task automatic cyc(input string tag, input bit e, input bit u,
                       input bit c, input bit l, input logic [7:0] d);
        exp_t x;
        en = e; up_dn = u; clr = c; load = l; din = d;
        #1;
        check_comb({tag, ".pre"});
        model_edge();
        q.push_back('{cnt: pack(m_v), err: m_err, done: m_done});
        @(posedge clk);
        #1;
        x = q.pop_front();
        check({tag, ".cnt"}, 32'(cnt), 32'(x.cnt));
        check({tag, ".err"}, 32'(load_err), 32'(x.err));
        check({tag, ".done"}, 32'(done), 32'(x.done));
    endtask

    initial begin
        #2;
        check("rst.cnt", 32'(cnt), 32'h0);
        check("rst.err", 32'(load_err), 32'h0);
        check("rst.done", 32'(done), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // async reset mid-count at 4,7
        cyc("ld47", 0, 1, 0, 1, 8'h47);
        cyc("cnt48", 1, 1, 0, 0, 8'h00);
        #2;
        rstn = 1'b0;
        #1;
        check("arst.cnt", 32'(cnt), 32'h0);
        check("arst.err", 32'(load_err), 32'h0);
        check("arst.tc_up", 32'(tc), 32'h0);
        up_dn = 1'b0;
        #1;
        check("arst.tc_dn", 32'(tc), 32'h1);
        m_v = 0; m_err = 0; m_done = 0;
        en = 1'b0;
        up_dn = 1'b1;
        @(negedge clk);
        rstn = 1'b1;

        // count up 99 steps, check wrap points, then en=0 at 9,9
        for (int i = 1; i <= 99; i++)
            cyc("up", 1, 1, 0, 0, 8'h00);
        check("up99.cnt", 32'(cnt), 32'h99);
        en = 1'b0;
        #1;
        check("up99.tc_en0", 32'(tc), 32'h1);
        check("up99.cout_en0", 32'(cout), 32'h0);
        en = 1'b1;
        #1;
        check("up99.cout", 32'(cout), 32'(!ONESHOT || !m_done));
        cyc("upwrap", 1, 1, 0, 0, 8'h00);

        // count down from 0,0
        cyc("clr", 0, 1, 1, 0, 8'h00);
        en = 1'b1; up_dn = 1'b0;
        #1;
        check("dn00.tc", 32'(tc), 32'h1);
        check("dn00.cout", 32'(cout), 32'h1);
        cyc("dn", 1, 0, 0, 0, 8'h00);
        cyc("dn", 1, 0, 0, 0, 8'h00);
        cyc("ld10", 0, 0, 0, 1, 8'h10);
        cyc("dn10", 1, 0, 0, 0, 8'h00);

        // clamped load, then legal load
        cyc("ld3f", 1, 1, 0, 1, 8'h3F);
        check("ld3f.val", 32'(cnt), 32'h39);
        cyc("hold", 0, 1, 0, 0, 8'h00);
        cyc("ld25", 1, 1, 0, 1, 8'h25);
        cyc("ldff", 0, 1, 0, 1, 8'hFF);

        // clr beats load and en
        cyc("ld55", 0, 1, 0, 1, 8'h55);
        cyc("clrall", 1, 1, 1, 1, 8'hFF);
        for (int i = 0; i < 6; i++)
            cyc("toggle", 1, (i % 2) == 0, 0, 0, 8'h00);

        // terminal-count behaviour at 9,9 (hold with done, or wrap)
        cyc("ld97", 0, 1, 0, 1, 8'h97);
        cyc("os98", 1, 1, 0, 0, 8'h00);
        cyc("os99", 1, 1, 0, 0, 8'h00);
        cyc("ostc", 1, 1, 0, 0, 8'h00);
        cyc("oshold", 1, 1, 0, 0, 8'h00);
        cyc("osdir", 1, 0, 0, 0, 8'h00);
        cyc("osld", 0, 1, 0, 1, 8'h00);
        cyc("osres", 1, 1, 0, 0, 8'h00);

        // down wrap under oneshot: load 0,0 then step down
        cyc("ld00", 0, 0, 0, 1, 8'h00);
        cyc("dntc", 1, 0, 0, 0, 8'h00);
        cyc("dnhold", 1, 0, 0, 0, 8'h00);

        // random mix
        for (int i = 0; i < 60; i++)
            cyc("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
                8'($urandom_range(0, 255)));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
